regfile_write_arbiter: RTL

Shares the write side of the CPU's register bank (NREG independent `W-bit registers, each with its own load strobe) among NREQ write requesters such as the ALU result path, the immediate-load path and the PC incrementer. Each cycle it grants at most one pending request, acknowledges it, and drives a registered one-hot load vector and write data into the register bank. It also flags writes to nonexistent registers and supports a sequencer-driven hold.

---
 rtl/regfile_write_arbiter_if.sv | 32 +++
 rtl/regfile_write_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-request bus between the CPU write requesters and the register-bank write arbiter.
// `W sets the register width (defaults to 4 when not defined by the build).
`ifndef W
`define W 4
`endif

interface regfile_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int NREG = 4
);
    localparam int AW = $clog2(NREG);

    logic                  hold;
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*`W-1:0]    req_dat;
    logic [NREQ-1:0]       ack;
    logic [NREG-1:0]       load;
    logic [`W-1:0]         wr_dat;
    logic                  err;
    logic                  err_clr;

    modport master (
        output hold, req, req_addr, req_dat, err_clr,
        input  ack, load, wr_dat, err
    );

    modport slave (
        input  hold, req, req_addr, req_dat, err_clr,
        output ack, load, wr_dat, err
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-bank write arbiter: combinational ack, registered one-hot load/wr_dat one cycle later; hold stalls grants.
// REGARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise fixed priority (lowest index wins).
`ifndef W
`define W 4
`endif

module regfile_write_arbiter #(
    parameter int NREQ = 4,
    parameter int NREG = 4
) (
    input  logic                    clk_cpu,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);
    localparam int AW = $clog2(NREG);
    localparam int IW = $clog2(NREQ);
    localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

    logic [NREQ-1:0]  w_ack;
    logic             w_gnt_vld;
    logic [IW-1:0]    w_gnt_idx;
    logic [AW-1:0]    w_gnt_addr;
    logic [`W-1:0]    w_gnt_dat;
    logic             w_gnt_inv;

    logic [NREG-1:0]  r_load;
    logic [`W-1:0]    r_wr_dat;
    logic             r_err;

`ifdef REGARB_ROUND_ROBIN_EN
    logic [IW-1:0]    r_ptr;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction
`endif

    // Scanning from the far end lets the nearest pending requester overwrite earlier hits.
    always_comb begin
        w_ack     = '0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if (!reset && !bus.hold) begin
            for (int k = NREQ-1; k >= 0; k--) begin
`ifdef REGARB_ROUND_ROBIN_EN
                if (bus.req[rr_idx(r_ptr, k)]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = rr_idx(r_ptr, k);
                end
`else
                if (bus.req[k]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = IW'(k);
                end
`endif
            end
        end
        if (w_gnt_vld) w_ack[w_gnt_idx] = 1'b1;
    end

    always_comb begin
        w_gnt_addr = bus.req_addr[w_gnt_idx*AW +: AW];
        w_gnt_dat  = bus.req_dat[w_gnt_idx*`W +: `W];
        w_gnt_inv  = w_gnt_vld && !({1'b0, w_gnt_addr} < NREG_L);
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            r_load   <= '0;
            r_wr_dat <= '0;
            r_err    <= 1'b0;
`ifdef REGARB_ROUND_ROBIN_EN
            r_ptr    <= '0;
`endif
        end else begin
            r_load <= '0;
            if (w_gnt_vld) begin
                r_wr_dat <= w_gnt_dat;
                if (!w_gnt_inv) r_load <= NREG'(1) << w_gnt_addr;
            end
            // A new invalid write outranks a simultaneous clear.
            if (w_gnt_inv)
                r_err <= 1'b1;
            else if (bus.err_clr)
                r_err <= 1'b0;
`ifdef REGARB_ROUND_ROBIN_EN
            if (w_gnt_vld)
                r_ptr <= (w_gnt_idx == IW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
`endif
        end
    end

    assign bus.ack    = w_ack;
    assign bus.load   = r_load;
    assign bus.wr_dat = r_wr_dat;
    assign bus.err    = r_err;

endmodule
